// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// Accepts one WIDTH-bit word over a valid/ready handshake and shifts it out
// one bit per clock on sout. Back-to-back frames run with no idle cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   load_data   word to transmit, captured on load_valid && load_ready
//   load_valid  producer has a word on load_data
//   load_ready  a word can be accepted this cycle (combinational)
//   sout        serial data bit (flop output)
//   sout_valid  sout carries a frame bit
//   sout_last   sout carries the final bit of the frame
//   busy        frame in progress
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic             last_q, last_d;
  logic             on_last, accept;

  assign on_last    = (state_q == SHIFT) && (cnt_q == LAST);
  // Ready on the final bit too, so the next word reloads with no gap.
  assign load_ready = !rst && ((state_q == IDLE) || on_last);
  assign accept     = load_valid && load_ready;

  // Zeros shift in behind the data, so the register is all-zero once a frame
  // drains and sout naturally reads 0 while idle.
  assign shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = load_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (accept) begin
            shreg_d = load_data;
          end else begin
            state_d = IDLE;
            shreg_d = shifted;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shreg_d = shifted;
        end
      end
      default: state_d = IDLE;
    endcase
    // sout_last is registered: flag the cycle whose counter will sit at LAST.
    last_d = (state_d == SHIFT) && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
    end
  end

  assign sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign sout_valid = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign sout_last  = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // u_m: WIDTH 8, MSB first
  logic [7:0] m_data;
  logic m_lv, m_rdy, m_sout, m_vld, m_last, m_busy;
  // u_l: WIDTH 8, LSB first
  logic [7:0] l_data;
  logic l_lv, l_rdy, l_sout, l_vld, l_last, l_busy;
  // u_w: WIDTH 1
  logic [0:0] w_data;
  logic w_lv, w_rdy, w_sout, w_vld, w_last, w_busy;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .load_data(m_data), .load_valid(m_lv), .load_ready(m_rdy),
    .sout(m_sout), .sout_valid(m_vld), .sout_last(m_last), .busy(m_busy));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .load_data(l_data), .load_valid(l_lv), .load_ready(l_rdy),
    .sout(l_sout), .sout_valid(l_vld), .sout_last(l_last), .busy(l_busy));
  piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w (
    .clk(clk), .rst(rst), .load_data(w_data), .load_valid(w_lv), .load_ready(w_rdy),
    .sout(w_sout), .sout_valid(w_vld), .sout_last(w_last), .busy(w_busy));

  // Scoreboard entry: {sout, sout_last}
  typedef logic [1:0] exp_t;
  exp_t q_m[$];
  exp_t q_l[$];
  exp_t q_w[$];

  function automatic void push_word(input logic [7:0] w, input bit msb, input bit to_l);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e[1] = msb ? w[7-i] : w[i];
      e[0] = (i == 7);
      if (to_l) q_l.push_back(e);
      else      q_m.push_back(e);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; m_lv = 1'b1; m_data = 8'hFF; l_lv = 1'b0; l_data = 8'h00;
    w_lv = 1'b0; w_data = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({m_sout, m_vld, m_last, m_busy, m_rdy} !== 5'b0) begin
      bad++; $display("FAIL reset_m: got %b want 00000", {m_sout, m_vld, m_last, m_busy, m_rdy});
    end
    total++;
    if ({l_sout, l_vld, l_last, l_busy, l_rdy, w_sout, w_vld, w_last, w_busy, w_rdy} !== 10'b0) begin
      bad++; $display("FAIL reset_lw: got %b want 0", {l_sout, l_vld, l_last, l_busy, l_rdy, w_sout, w_vld, w_last, w_busy, w_rdy});
    end
    rst = 1'b0; m_lv = 1'b0;
    @(negedge clk);
    total++;
    if ({m_vld, m_rdy} !== 2'b01) begin
      bad++; $display("FAIL reset_release: got vld/rdy=%b want 01", {m_vld, m_rdy});
    end
  endtask

  task automatic test_msb_first();
    exp_t e;
    m_data = 8'hA5; m_lv = 1'b1; push_word(8'hA5, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      // changing load_data after the accept must not disturb the frame
      if (k == 0) begin m_lv = 1'b0; m_data = 8'h00; end
      e = q_m.pop_front();
      total++;
      if ({m_vld, m_busy, m_sout, m_last} !== {2'b11, e}) begin
        bad++; $display("FAIL msb_a5 bit%0d: got %b want %b", k, {m_vld, m_busy, m_sout, m_last}, {2'b11, e});
      end
    end
    @(negedge clk);
    total++;
    if ({m_vld, m_busy, m_last, m_sout, m_rdy} !== 5'b00001) begin
      bad++; $display("FAIL msb_after: got %b want 00001", {m_vld, m_busy, m_last, m_sout, m_rdy});
    end
  endtask

  task automatic test_lsb_first();
    exp_t e;
    logic [7:0] words [2];
    words[0] = 8'hA5; words[1] = 8'h01;
    for (int w = 0; w < 2; w++) begin
      l_data = words[w]; l_lv = 1'b1; push_word(words[w], 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k == 0) begin l_lv = 1'b0; l_data = 8'hFF; end
        e = q_l.pop_front();
        total++;
        if ({l_vld, l_busy, l_sout, l_last} !== {2'b11, e}) begin
          bad++; $display("FAIL lsb_w%0d bit%0d: got %b want %b", w, k, {l_vld, l_busy, l_sout, l_last}, {2'b11, e});
        end
      end
      @(negedge clk);
      total++;
      if ({l_vld, l_busy, l_sout} !== 3'b000) begin
        bad++; $display("FAIL lsb_idle w%0d: got %b want 000", w, {l_vld, l_busy, l_sout});
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    m_data = 8'hF0; m_lv = 1'b1;
    push_word(8'hF0, 1'b1, 1'b0);
    push_word(8'h0F, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) m_data = 8'h0F;
      if (k == 8) m_lv = 1'b0;
      e = q_m.pop_front();
      total++;
      if ({m_vld, m_busy, m_sout, m_last, m_rdy} !== {2'b11, e, (k == 7 || k == 15)}) begin
        bad++; $display("FAIL b2b cyc%0d: got %b want %b", k, {m_vld, m_busy, m_sout, m_last, m_rdy},
                        {2'b11, e, (k == 7 || k == 15)});
      end
    end
    @(negedge clk);
    total++;
    if ({m_vld, m_busy, m_rdy} !== 3'b001) begin
      bad++; $display("FAIL b2b_after: got %b want 001", {m_vld, m_busy, m_rdy});
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    m_data = 8'hFF; m_lv = 1'b1; push_word(8'hFF, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) m_lv = 1'b0;
      e = q_m.pop_front();
      total++;
      if ({m_vld, m_sout, m_last} !== {1'b1, e}) begin
        bad++; $display("FAIL abort_pre bit%0d: got %b want %b", k, {m_vld, m_sout, m_last}, {1'b1, e});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_m.delete();
    total++;
    if ({m_sout, m_vld, m_last, m_busy} !== 4'b0) begin
      bad++; $display("FAIL abort_post: got %b want 0000", {m_sout, m_vld, m_last, m_busy});
    end
    @(negedge clk);
    total++;
    if ({m_vld, m_rdy} !== 2'b01) begin
      bad++; $display("FAIL abort_noresume: got %b want 01", {m_vld, m_rdy});
    end
    m_data = 8'h81; m_lv = 1'b1; push_word(8'h81, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) m_lv = 1'b0;
      e = q_m.pop_front();
      total++;
      if ({m_vld, m_sout, m_last} !== {1'b1, e}) begin
        bad++; $display("FAIL abort_81 bit%0d: got %b want %b", k, {m_vld, m_sout, m_last}, {1'b1, e});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_rst_with_valid();
    rst = 1'b1; m_lv = 1'b1; m_data = 8'h55;
    #1;
    total++;
    if (m_rdy !== 1'b0) begin
      bad++; $display("FAIL rstvalid_rdy: got %b want 0", m_rdy);
    end
    @(negedge clk);
    rst = 1'b0; m_lv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({m_vld, m_busy, m_sout} !== 3'b000) begin
        bad++; $display("FAIL rstvalid_noaccept cyc%0d: got %b want 000", k, {m_vld, m_busy, m_sout});
      end
    end
  endtask

  task automatic test_width1();
    exp_t e;
    logic [2:0] bits;
    bits = 3'b101;
    w_lv = 1'b1; w_data = bits[2];
    q_w.push_back({bits[2], 1'b1});
    q_w.push_back({bits[1], 1'b1});
    q_w.push_back({bits[0], 1'b1});
    #1;
    total++;
    if (w_rdy !== 1'b1) begin
      bad++; $display("FAIL w1_rdy_idle: got %b want 1", w_rdy);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) w_data = bits[1-k];
      else       w_lv = 1'b0;
      e = q_w.pop_front();
      total++;
      if ({w_vld, w_busy, w_sout, w_last, w_rdy} !== {2'b11, e, 1'b1}) begin
        bad++; $display("FAIL w1 bit%0d: got %b want %b", k, {w_vld, w_busy, w_sout, w_last, w_rdy}, {2'b11, e, 1'b1});
      end
    end
    @(negedge clk);
    total++;
    if ({w_vld, w_last, w_sout} !== 3'b000) begin
      bad++; $display("FAIL w1_after: got %b want 000", {w_vld, w_last, w_sout});
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_reset_midframe();
    test_rst_with_valid();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on sout.
- Serves as the transmitting end that feeds our serial-capture flip-flop chains. It drives the single-bit data line they sample.
- Supports gapless back-to-back frames. All outputs are registered except load_ready.

Parameters:
- WIDTH, 8, word length in bits; legal range 1 to 32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- load_data  input  WIDTH  word to transmit; sampled on handshake.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  serializer can accept a word this cycle (combinational).
- sout  output  1  serial data bit (registered).
- sout_valid  output  1  sout carries a frame bit this cycle.
- sout_last  output  1  sout carries the final bit of the frame.
- busy  output  1  frame in progress (state == SHIFT).

Behaviour:
- Reset: rst high at posedge clk sets the following, regardless of other inputs:
  - state = IDLE, bit counter = 0, shift register = 0;
  - sout = 0, sout_valid = 0, sout_last = 0, busy = 0.
- load_ready = !rst && (state == IDLE || (state == SHIFT && counter == WIDTH-1)).
- Handshake: a word is accepted at the posedge where load_valid && load_ready. load_data is captured only then and is ignored otherwise.
- States:
  - IDLE: sout = 0, sout_valid = 0. On accept, go to SHIFT, load the shift register, counter = 0.
  - SHIFT: each cycle present the current bit and increment the counter.
    - At counter == WIDTH-1 with no accept, return to IDLE.
    - At counter == WIDTH-1 with an accept, reload and stay in SHIFT with counter = 0. This gives a gapless next frame.
- Latency: the first bit appears on sout one cycle after the accepting edge. A frame occupies exactly WIDTH consecutive cycles of sout_valid = 1.
- Bit order:
  - MSB_FIRST = 1: bit WIDTH-1 down to bit 0.
  - MSB_FIRST = 0: bit 0 up to bit WIDTH-1.
- sout_last = 1 only in the cycle carrying the final bit, and always with sout_valid = 1.
- busy equals sout_valid.
- Changes to load_data after the accept have no effect on the frame in flight.
- load_valid held high continuously: frames stream with zero idle cycles and sout_valid stays high.
- WIDTH = 1: load_ready is high whenever !rst. Every bit has sout_last = 1.
- Reset mid-frame aborts the frame. Outputs are at reset values in the cycle after the reset edge. No partial frame resumes.
- rst and load_valid high together: reset wins, the word is not accepted, and load_ready = 0.
- Counter width: clog2(WIDTH) bits, minimum 1. It never exceeds WIDTH-1.

Test Plan:
1. Reset, then load 8'hA5 with MSB_FIRST=1 -> sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept. sout_last high on the 8th bit only; busy low afterwards.
2. Same word with MSB_FIRST=0 -> sout = 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 for bits 0..7 of 8'hA5. Also repeat with 8'h01 -> 1,0,0,0,0,0,0,0.
3. load_valid held high with words 8'hF0 then 8'h0F -> 16 consecutive sout_valid cycles with no gap. sout_last high on cycles 8 and 16; load_ready high only in IDLE and on the last-bit cycles.
4. Accept 8'hFF, assert rst for 1 cycle after the 3rd bit -> next cycle sout=0, sout_valid=0, busy=0. A following load of 8'h81 transmits cleanly as 1,0,0,0,0,0,0,1.
5. rst and load_valid both high with 8'h55 -> no accept and load_ready=0. After rst drops, sout_valid stays 0 until a new handshake.
6. WIDTH=1: load 1, 0, 1 back-to-back -> sout = 1,0,1 with sout_valid and sout_last high on all three cycles.
